// File: rtl/l1_mem_pkg.sv
// rtl/l1_mem_pkg.sv - shared types and constants for the L1 refill controller
// Contents: line geometry, refill FSM state encoding, miss side encoding.
package l1_mem_pkg;

  localparam int LINE_W   = 64;
  localparam int LINE_OFF = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BEAT,
    FILL,
    WR_REQ,
    WR_WAIT
  } refill_state_t;

  typedef enum logic {
    SIDE_D = 1'b0,
    SIDE_I = 1'b1
  } side_t;

endpackage

// File: rtl/l1_write_buffer.sv
// rtl/l1_write_buffer.sv - posted-write FIFO feeding the memory port
// Ports: clk, rst (sync, active-high); push/push_data enqueue (ignored when
// full); pop dequeues (ignored when empty); full, empty status; head = oldest.
module l1_write_buffer #(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  // Fullness is judged on the current count only, so a push into a full
  // buffer is refused even when a pop frees a slot in the same cycle.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/l1_refill_ctrl.sv
// rtl/l1_refill_ctrl.sv - L1 miss refill and write-through drain controller
// Ports: miss_d_*/miss_i_* level miss requests; wr_req/wr_addr/wr_data/wr_ready
// posted byte writes; fill_* one-cycle line delivery; write_done per write ack;
// mem_req_* request channel and mem_resp_* read beats / write acks.
module l1_refill_ctrl
  import l1_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int MEM_W    = 16,
  parameter int WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_d_req,
  input  logic [ADDR_W-1:0] miss_d_addr,
  input  logic              miss_i_req,
  input  logic [ADDR_W-1:0] miss_i_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              fill_valid,
  output logic              fill_is_inst,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_line,
  output logic              write_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [7:0]        mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [MEM_W-1:0]  mem_resp_data
);

  localparam int BEATS  = LINE_W / MEM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  refill_state_t       state;
  refill_state_t       state_next;
  side_t               side_q;
  logic [ADDR_W-1:0]   line_addr_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [LINE_W-1:0]   line_buf;
  logic [LINE_W-1:0]   line_merged;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   sel_line;
  logic                any_miss;
  logic                last_beat;

  logic                wb_full;
  logic                wb_empty;
  logic                wb_pop;
  logic [ADDR_W+7:0]   wb_head;

  l1_write_buffer #(
    .DEPTH   (WB_DEPTH),
    .ENTRY_W (ADDR_W + 8)
  ) u_wb (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_req),
    .push_data ({wr_addr, wr_data}),
    .pop       (wb_pop),
    .full      (wb_full),
    .empty     (wb_empty),
    .head      (wb_head)
  );

  assign wr_ready = !wb_full;

  // The data side wins a simultaneous miss; the instruction miss stays
  // raised and is picked up on a later IDLE visit.
  assign any_miss  = miss_d_req || miss_i_req;
  assign sel_addr  = miss_d_req ? miss_d_addr : miss_i_addr;
  assign sel_line  = sel_addr & ~ADDR_W'((1 << LINE_OFF) - 1);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Current line with the incoming beat dropped into its slot; used both to
  // accumulate beats and to publish the complete line on the final beat.
  always_comb begin
    line_merged = line_buf;
    line_merged[beat_q*MEM_W +: MEM_W] = mem_resp_data;
  end

  always_comb begin
    state_next = state;
    wb_pop     = 1'b0;
    case (state)
      IDLE: begin
        // Posted writes drain first so a refill sees them in memory.
        if (!wb_empty)     state_next = WR_REQ;
        else if (any_miss) state_next = RD_REQ;
      end
      RD_REQ: begin
        if (mem_req_ready) state_next = RD_BEAT;
      end
      RD_BEAT: begin
        if (mem_resp_valid && last_beat) state_next = FILL;
      end
      FILL: begin
        state_next = IDLE;
      end
      WR_REQ: begin
        if (mem_req_ready) begin
          wb_pop     = 1'b1;
          state_next = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (mem_resp_valid) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      side_q        <= SIDE_D;
      line_addr_q   <= '0;
      beat_q        <= '0;
      line_buf      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      fill_valid    <= 1'b0;
      fill_is_inst  <= 1'b0;
      fill_addr     <= '0;
      fill_line     <= '0;
      write_done    <= 1'b0;
    end else begin
      state         <= state_next;
      mem_req_valid <= (state_next == RD_REQ) || (state_next == WR_REQ);
      fill_valid    <= (state_next == FILL);
      write_done    <= (state == WR_WAIT) && mem_resp_valid;

      // Request fields are loaded only on leaving IDLE, which keeps them
      // stable for as long as the memory stalls the handshake.
      if (state == IDLE) begin
        if (!wb_empty) begin
          mem_req_we    <= 1'b1;
          mem_req_addr  <= wb_head[ADDR_W+7:8];
          mem_req_wdata <= wb_head[7:0];
        end else if (any_miss) begin
          mem_req_we   <= 1'b0;
          mem_req_addr <= sel_line;
          line_addr_q  <= sel_line;
          side_q       <= miss_d_req ? SIDE_D : SIDE_I;
        end
      end

      if (state == RD_REQ && mem_req_ready) begin
        beat_q <= '0;
      end

      if (state == RD_BEAT && mem_resp_valid) begin
        line_buf <= line_merged;
        beat_q   <= beat_q + 1'b1;
      end

      if (state_next == FILL) begin
        fill_line    <= line_merged;
        fill_addr    <= line_addr_q;
        fill_is_inst <= (side_q == SIDE_I);
      end
    end
  end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb/tb_l1_refill_ctrl.sv - directed self-checking bench for l1_refill_ctrl
module tb_l1_refill_ctrl;

  localparam int ADDR_W   = 16;
  localparam int MEM_W    = 16;
  localparam int WB_DEPTH = 2;

  logic              clk;
  logic              rst;
  logic              miss_d_req;
  logic [ADDR_W-1:0] miss_d_addr;
  logic              miss_i_req;
  logic [ADDR_W-1:0] miss_i_addr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              fill_valid;
  logic              fill_is_inst;
  logic [ADDR_W-1:0] fill_addr;
  logic [63:0]       fill_line;
  logic              write_done;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [7:0]        mem_req_wdata;
  logic              mem_resp_valid;
  logic [MEM_W-1:0]  mem_resp_data;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int miss_edge = 0;
  int fill_edge = 0;

  l1_refill_ctrl #(
    .ADDR_W   (ADDR_W),
    .MEM_W    (MEM_W),
    .WB_DEPTH (WB_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .miss_d_req     (miss_d_req),
    .miss_d_addr    (miss_d_addr),
    .miss_i_req     (miss_i_req),
    .miss_i_addr    (miss_i_addr),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .fill_valid     (fill_valid),
    .fill_is_inst   (fill_is_inst),
    .fill_addr      (fill_addr),
    .fill_line      (fill_line),
    .write_done     (write_done),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Non-line outputs packed; in reset only wr_ready (LSB) is 1.
  function automatic logic [63:0] ctl_vec();
    return 64'({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
                fill_valid, fill_is_inst, fill_addr, write_done, wr_ready});
  endfunction

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    check({tag, " req_seen"}, 64'(mem_req_valid), 64'd1);
  endtask

  task automatic serve_read(input string tag, input logic [15:0] exp_addr,
                            input logic [63:0] line, input bit exp_inst,
                            input int ready_delay, input int gap, input bit junk);
    wait_req(tag);
    check({tag, " rd_addr"}, 64'(mem_req_addr), 64'(exp_addr));
    check({tag, " rd_we"}, 64'(mem_req_we), 64'd0);
    for (int i = 0; i < ready_delay; i++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = junk && (i == 1);
      mem_resp_data  = 16'hDEAD;
      tick;
      check({tag, " rd_hold"}, 64'({mem_req_valid, mem_req_we, mem_req_addr}),
            64'({1'b1, 1'b0, exp_addr}));
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick;
    mem_req_ready  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_resp_valid = 1'b0;
        tick;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = line[16*b +: 16];
      tick;
    end
    mem_resp_valid = 1'b0;
    fill_edge = edge_cnt;
    check({tag, " fill_valid"}, 64'(fill_valid), 64'd1);
    check({tag, " fill_line"}, fill_line, line);
    check({tag, " fill_addr"}, 64'(fill_addr), 64'(exp_addr));
    check({tag, " fill_is_inst"}, 64'(fill_is_inst), 64'(exp_inst));
    if (exp_inst) miss_i_req = 1'b0;
    else          miss_d_req = 1'b0;
    tick;
    check({tag, " fill_pulse_end"}, 64'(fill_valid), 64'd0);
    check({tag, " fill_line_hold"}, fill_line, line);
  endtask

  task automatic serve_write(input string tag, input logic [15:0] exp_addr,
                             input logic [7:0] exp_data, input int ack_delay);
    wait_req(tag);
    check({tag, " wr_fields"}, 64'({mem_req_we, mem_req_addr, mem_req_wdata}),
          64'({1'b1, exp_addr, exp_data}));
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    check({tag, " wait_valid_low"}, 64'(mem_req_valid), 64'd0);
    for (int i = 0; i < ack_delay; i++) tick;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 16'h0000;
    tick;
    mem_resp_valid = 1'b0;
    check({tag, " write_done"}, 64'(write_done), 64'd1);
    check({tag, " no_fill_at_done"}, 64'(fill_valid), 64'd0);
    tick;
    check({tag, " write_done_end"}, 64'(write_done), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    miss_d_req     = 1'b0;
    miss_d_addr    = '0;
    miss_i_req     = 1'b0;
    miss_i_addr    = '0;
    wr_req         = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (3) tick;
    check("reset ctl", ctl_vec(), 64'd1);
    check("reset fill_line", fill_line, 64'd0);
    rst = 1'b0;
    tick;

    // D miss with immediate ready and back-to-back beats.
    miss_d_req  = 1'b1;
    miss_d_addr = 16'h1234;
    miss_edge   = edge_cnt;
    serve_read("dmiss", 16'h1230, 64'h1100_FFEE_DDCC_BBAA, 1'b0, 0, 0, 1'b0);
    // Inclusive count: the IDLE cycle that sees the miss through the FILL cycle.
    check("dmiss latency", 64'(fill_edge - miss_edge + 1), 64'd7);
    tick;

    // Simultaneous D and I misses: D first, then I.
    miss_d_req  = 1'b1;
    miss_d_addr = 16'h0040;
    miss_i_req  = 1'b1;
    miss_i_addr = 16'h0085;
    serve_read("dual_d", 16'h0040, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 1'b0);
    serve_read("dual_i", 16'h0080, 64'hCAFE_F00D_1357_2468, 1'b1, 0, 0, 1'b0);
    tick;

    // Three consecutive writes with memory stalled: third is refused.
    wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 8'h5A;
    check("wb ready0", 64'(wr_ready), 64'd1);
    tick;
    wr_addr = 16'h0011; wr_data = 8'hA5;
    check("wb ready1", 64'(wr_ready), 64'd1);
    tick;
    wr_addr = 16'h0012; wr_data = 8'h3C;
    check("wb ready2_full", 64'(wr_ready), 64'd0);
    tick;
    wr_req = 1'b0;
    check("wb still_full", 64'(wr_ready), 64'd0);
    tick;
    tick;
    serve_write("wb0", 16'h0010, 8'h5A, 1);
    serve_write("wb1", 16'h0011, 8'hA5, 0);
    repeat (4) tick;
    check("wb third_refused", 64'(mem_req_valid), 64'd0);
    check("wb ready_again", 64'(wr_ready), 64'd1);

    // Posted write drains before a read to the same line.
    wr_req = 1'b1; wr_addr = 16'h0020; wr_data = 8'h77;
    tick;
    wr_req      = 1'b0;
    miss_d_req  = 1'b1;
    miss_d_addr = 16'h0020;
    serve_write("raw_wr", 16'h0020, 8'h77, 0);
    serve_read("raw_rd", 16'h0020, 64'h0000_0000_0000_0077, 1'b0, 0, 0, 1'b0);
    tick;

    // Slow memory: ready delayed, gapped beats, stray resp during RD_REQ.
    miss_d_req  = 1'b1;
    miss_d_addr = 16'h0A0F;
    serve_read("slow", 16'h0A08, 64'h8877_6655_4433_2211, 1'b0, 5, 3, 1'b1);
    tick;

    // Reset after two of four beats.
    miss_d_req  = 1'b1;
    miss_d_addr = 16'h0300;
    wait_req("rst_mid");
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 16'h9900 + 16'(b);
      tick;
    end
    mem_resp_valid = 1'b0;
    miss_d_req     = 1'b0;
    rst            = 1'b1;
    tick;
    check("rst_mid ctl", ctl_vec(), 64'd1);
    check("rst_mid fill_line", fill_line, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rst_mid quiet", 64'({fill_valid, mem_req_valid, write_done}), 64'd0);
    end
    miss_d_req  = 1'b1;
    miss_d_addr = 16'h0408;
    serve_read("post_rst", 16'h0408, 64'hA1A2_B1B2_C1C2_D1D2, 1'b0, 0, 0, 1'b0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
